// File: rtl/booth_mult_pkg.sv
// Shared definitions for the radix-4 Booth pipelined multiplier.
//   - Booth digit encodings (triplet {a[2k+1], a[2k], a[2k-1]})
//   - n_pp / n_stages : pipeline geometry helpers
//   - q_max / q_min   : signed saturation bounds for a WIDTH-bit result
package booth_mult_pkg;

  // Booth triplet encodings and the term each one selects
  localparam logic [2:0] BOOTH_ZERO_LO = 3'b000;  //  0
  localparam logic [2:0] BOOTH_POS1_A  = 3'b001;  // +b
  localparam logic [2:0] BOOTH_POS1_B  = 3'b010;  // +b
  localparam logic [2:0] BOOTH_POS2    = 3'b011;  // +2b
  localparam logic [2:0] BOOTH_NEG2    = 3'b100;  // -2b
  localparam logic [2:0] BOOTH_NEG1_A  = 3'b101;  // -b
  localparam logic [2:0] BOOTH_NEG1_B  = 3'b110;  // -b
  localparam logic [2:0] BOOTH_ZERO_HI = 3'b111;  //  0

  // Number of radix-4 Booth digits for a w-bit multiplicand
  function automatic int unsigned n_pp(input int unsigned w);
    return w / 2;
  endfunction

  // Accumulate stages needed when pps digits are summed per stage
  function automatic int unsigned n_stages(input int unsigned w, input int unsigned pps);
    return (w / 2 + pps - 1) / pps;
  endfunction

  // Largest representable w-bit two's complement value (w <= 63)
  function automatic logic signed [63:0] q_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Smallest representable w-bit two's complement value (w <= 63)
  function automatic logic signed [63:0] q_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/booth_mult_pipe_pp_gen.sv
// Combinational radix-4 Booth partial-product generator.
// Ports:
//   digit : Booth triplet {a[2k+1], a[2k], a[2k-1]}
//   b     : signed multiplier operand (WIDTH bits)
//   k     : digit index; the selected term is weighted by 4^k
//   pp    : 2*WIDTH-bit two's complement partial product
module booth_pp_gen
  import booth_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned KW    = 4
) (
  input  logic [2:0]         digit,
  input  logic [WIDTH-1:0]   b,
  input  logic [KW-1:0]      k,
  output logic [2*WIDTH-1:0] pp
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0] b_ext;
  logic [PW-1:0] term;

  // Select 0/+-b/+-2b, then weight by 4^k; modulo-2^PW arithmetic is exact here
  always_comb begin
    b_ext = {{WIDTH{b[WIDTH-1]}}, b};
    term  = '0;
    unique case (digit)
      BOOTH_POS1_A, BOOTH_POS1_B: term = b_ext;
      BOOTH_POS2:                 term = b_ext << 1;
      BOOTH_NEG2:                 term = -(b_ext << 1);
      BOOTH_NEG1_A, BOOTH_NEG1_B: term = -b_ext;
      BOOTH_ZERO_LO, BOOTH_ZERO_HI: term = '0;
      default:                    term = '0;
    endcase
    pp = term << {k, 1'b0};
  end

endmodule

// File: rtl/booth_mult_pipe.sv
// Pipelined signed fixed-point multiplier (radix-4 Booth) with valid/ready.
// Result is Q(WIDTH-FRAC).FRAC, product >>> FRAC with saturation to WIDTH bits.
// Pipeline: input register -> STAGES accumulate stages -> output register.
// A single advance signal stalls every register when the output is blocked.
// Optional macro BOOTH_MULT_ROUND_EN: round-half-up instead of floor.
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid / in_ready : operand handshake (in_ready is combinational)
//   a, b                : signed operands (a is Booth recoded)
//   out_valid/out_ready : result handshake
//   p, sat              : registered product and clamp flag
module booth_mult_pipe
  import booth_mult_pkg::*;
#(
  parameter int unsigned WIDTH        = 24,
  parameter int unsigned FRAC         = 22,
  parameter int unsigned PP_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] p,
  output logic             sat
);

  localparam int unsigned N_PP   = n_pp(WIDTH);
  localparam int unsigned STAGES = n_stages(WIDTH, PP_PER_STAGE);
  localparam int unsigned PW     = 2 * WIDTH;
  localparam int unsigned N_SLOT = STAGES * PP_PER_STAGE;
  localparam int unsigned KW     = $clog2(N_PP);

  localparam logic signed [PW-1:0] Q_MAX = PW'(q_max(WIDTH));
  localparam logic signed [PW-1:0] Q_MIN = PW'(q_min(WIDTH));
`ifdef BOOTH_MULT_ROUND_EN
  localparam logic signed [PW-1:0] HALF_LSB = PW'(1) << (FRAC - 1);
`endif

  logic adv_c;

  // a_q[0]/b_q[0] are the input register; a_q[s]/b_q[s] feed accumulate stage s
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  // vld_q[0] tags the input register, vld_q[s+1] tags accumulate stage s
  logic [STAGES:0]  vld_q;
  logic [STAGES:0]  vld_d;
  logic [PW-1:0]    acc_q   [STAGES];
  logic [PW-1:0]    acc_d   [STAGES];
  logic [PW-1:0]    acc_in_c[STAGES];
  logic [PW-1:0]    pp_c    [N_SLOT];
  logic [PW-1:0]    stage_sum;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic             sat_q, sat_d;

  logic signed [PW-1:0] prod_c;
  logic signed [PW-1:0] q_c;
  logic [WIDTH-1:0]     res_p_c;
  logic                 res_sat_c;

  // Global stall: everything moves unless a result is waiting to be taken
  assign adv_c    = !out_valid_q || out_ready;
  assign in_ready = adv_c;

  // Booth digit generators; slot k lives in stage k / PP_PER_STAGE, unused slots are zero
  for (genvar k = 0; k < N_SLOT; k++) begin : g_pp
    if (k < N_PP) begin : g_dig
      logic [2:0] digit_c;
      if (k == 0) begin : g_lsd
        assign digit_c = {a_q[0][1:0], 1'b0};
      end else begin : g_msd
        assign digit_c = a_q[k / PP_PER_STAGE][2*k+1 -: 3];
      end
      booth_pp_gen #(
        .WIDTH (WIDTH),
        .KW    (KW)
      ) u_pp (
        .digit (digit_c),
        .b     (b_q[k / PP_PER_STAGE]),
        .k     (KW'(k)),
        .pp    (pp_c[k])
      );
    end else begin : g_pad
      assign pp_c[k] = '0;
    end
  end

  // Running sum entering each stage: zero for the first stage
  for (genvar s = 0; s < STAGES; s++) begin : g_acc_in
    if (s == 0) begin : g_first
      assign acc_in_c[s] = '0;
    end else begin : g_next
      assign acc_in_c[s] = acc_q[s-1];
    end
  end

  // Scale by FRAC (optionally rounded) and clamp into WIDTH bits
  always_comb begin
    prod_c    = $signed(acc_q[STAGES-1]);
`ifdef BOOTH_MULT_ROUND_EN
    prod_c    = prod_c + HALF_LSB;
`endif
    q_c       = prod_c >>> FRAC;
    res_p_c   = q_c[WIDTH-1:0];
    res_sat_c = 1'b0;
    if (q_c > Q_MAX) begin
      res_p_c   = {1'b0, {(WIDTH-1){1'b1}}};
      res_sat_c = 1'b1;
    end else if (q_c < Q_MIN) begin
      res_p_c   = {1'b1, {(WIDTH-1){1'b0}}};
      res_sat_c = 1'b1;
    end
  end

  // Next-state: hold everything on stall, otherwise shift the pipeline one step
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    vld_d       = vld_q;
    out_valid_d = out_valid_q;
    p_d         = p_q;
    sat_d       = sat_q;
    stage_sum   = '0;
    if (adv_c) begin
      vld_d[0] = in_valid;
      a_d[0]   = a;
      b_d[0]   = b;
      for (int s = 0; s < STAGES; s++) begin
        stage_sum = acc_in_c[s];
        for (int j = 0; j < PP_PER_STAGE; j++) begin
          stage_sum = stage_sum + pp_c[s*PP_PER_STAGE + j];
        end
        acc_d[s]   = stage_sum;
        vld_d[s+1] = vld_q[s];
      end
      for (int s = 1; s < STAGES; s++) begin
        a_d[s] = a_q[s-1];
        b_d[s] = b_q[s-1];
      end
      out_valid_d = vld_q[STAGES];
      // p/sat only change when a real result lands, so they hold across bubbles
      if (vld_q[STAGES]) begin
        p_d   = res_p_c;
        sat_d = res_sat_c;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        acc_q[s] <= '0;
      end
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      p_q         <= '0;
      sat_q       <= 1'b0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        a_q[s]   <= a_d[s];
        b_q[s]   <= b_d[s];
        acc_q[s] <= acc_d[s];
      end
      vld_q       <= vld_d;
      out_valid_q <= out_valid_d;
      p_q         <= p_d;
      sat_q       <= sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign p         = p_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_booth_mult_pipe.sv
// Directed/self-checking bench for booth_mult_pipe (defaults plus WIDTH=16 sweep).
module tb_booth_mult_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, sat;
  logic [23:0] a, b, p;

  logic        v16;
  logic [15:0] a16, b16;
  logic        or16 = 1'b1;
  logic        ir16 [3];
  logic        ov16 [3];
  logic [15:0] p16  [3];
  logic        s16  [3];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [24:0] exp_q[$];
  logic [16:0] exp16[64];
  int          n16 = 0;
  int          idx16[3] = '{0, 0, 0};
  int          pps16[3] = '{1, 3, 8};
  int          lat16_exp[3] = '{10, 5, 3};

  always #5 clk = ~clk;

  booth_mult_pipe #(.WIDTH(24), .FRAC(22), .PP_PER_STAGE(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .p(p), .sat(sat));

  booth_mult_pipe #(.WIDTH(16), .FRAC(14), .PP_PER_STAGE(1)) u_w16_p1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(ir16[0]),
    .a(a16), .b(b16), .out_valid(ov16[0]), .out_ready(or16), .p(p16[0]), .sat(s16[0]));

  booth_mult_pipe #(.WIDTH(16), .FRAC(14), .PP_PER_STAGE(3)) u_w16_p3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(ir16[1]),
    .a(a16), .b(b16), .out_valid(ov16[1]), .out_ready(or16), .p(p16[1]), .sat(s16[1]));

  booth_mult_pipe #(.WIDTH(16), .FRAC(14), .PP_PER_STAGE(8)) u_w16_p8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(ir16[2]),
    .a(a16), .b(b16), .out_valid(ov16[2]), .out_ready(or16), .p(p16[2]), .sat(s16[2]));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: exact product, optional half-LSB add, floor shift, clamp
  function automatic void model(input logic [31:0] av, input logic [31:0] bv,
                                input int w, input int f,
                                output logic [31:0] pe, output logic se);
    longint sa, sb, pr, q, mx, mn, mask;
    sa = longint'(av) <<< (64 - w);
    sa = sa >>> (64 - w);
    sb = longint'(bv) <<< (64 - w);
    sb = sb >>> (64 - w);
    pr = sa * sb;
`ifdef BOOTH_MULT_ROUND_EN
    pr = pr + (longint'(1) <<< (f - 1));
`endif
    q    = pr >>> f;
    mx   = (longint'(1) <<< (w - 1)) - 1;
    mn   = -(longint'(1) <<< (w - 1));
    mask = (longint'(1) <<< w) - 1;
    se   = 1'b0;
    if (q > mx) begin
      q  = mx;
      se = 1'b1;
    end else if (q < mn) begin
      q  = mn;
      se = 1'b1;
    end
    pe = 32'(q & mask);
  endfunction

  // One clock of the 24-bit DUT: drive, then check handshake and any delivered result
  task automatic cycle(input logic iv, input logic [23:0] ia, input logic [23:0] ib,
                       input logic ordy, input logic use_model,
                       output logic took, output logic got);
    logic [24:0] e;
    logic [31:0] pe;
    logic        se;
    @(posedge clk);
    #1;
    cyc++;
    in_valid  = iv;
    a         = ia;
    b         = ib;
    out_ready = ordy;
    #1;
    check("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
    got  = out_valid && out_ready;
    took = iv && in_ready;
    if (got) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 64'(out_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("p", 64'(p), 64'(e[23:0]));
        check("sat", 64'(sat), 64'(e[24]));
      end
    end
    if (took && use_model) begin
      model(32'(ia), 32'(ib), 24, 22, pe, se);
      exp_q.push_back({se, pe[23:0]});
    end
  endtask

  // Single directed vector with hand-computed result and latency check
  task automatic dir_vec(input string tag, input logic [23:0] ia, input logic [23:0] ib,
                         input logic [23:0] ep, input logic es);
    logic took, got;
    int   lat;
    exp_q.delete();
    exp_q.push_back({es, ep});
    cycle(1'b1, ia, ib, 1'b1, 1'b0, took, got);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      cycle(1'b0, 24'd0, 24'd0, 1'b1, 1'b0, took, got);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd8);
    exp_q.delete();
  endtask

  // One clock of the three WIDTH=16 instances sharing stimulus
  task automatic cyc16(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                       output logic [2:0] got);
    logic [31:0] pe;
    logic        se;
    @(posedge clk);
    #1;
    v16 = iv;
    a16 = ia;
    b16 = ib;
    #1;
    for (int i = 0; i < 3; i++) begin
      got[i] = ov16[i];
      if (ov16[i]) begin
        if (idx16[i] < n16) begin
          check($sformatf("w16_pps%0d_p", pps16[i]), 64'(p16[i]), 64'(exp16[idx16[i]][15:0]));
          check($sformatf("w16_pps%0d_sat", pps16[i]), 64'(s16[i]), 64'(exp16[idx16[i]][16]));
          idx16[i]++;
        end else begin
          check($sformatf("w16_pps%0d_spurious", pps16[i]), 64'(ov16[i]), 64'd0);
        end
      end
    end
    if (iv) begin
      model(32'(ia), 32'(ib), 16, 14, pe, se);
      exp16[n16] = {se, pe[15:0]};
      n16++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        took, got;
    logic [2:0]  g3;
    logic [23:0] ra, rb;
    int          n_acc, k, first_c, last_c, cnt, lat16[3];

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    v16 = 1'b0; a16 = '0; b16 = '0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_p", 64'(p), 64'd0);
    check("rst_sat", 64'(sat), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Directed vectors, defaults
    dir_vec("one_x_one",   24'h400000, 24'h400000, 24'h400000, 1'b0);
    dir_vec("neg_clamp",   24'h600000, 24'hA00000, 24'h800000, 1'b1);
    dir_vec("min_x_min",   24'h800000, 24'h800000, 24'h7FFFFF, 1'b1);
    dir_vec("min_x_one",   24'h800000, 24'h400000, 24'h800000, 1'b0);
`ifdef BOOTH_MULT_ROUND_EN
    dir_vec("round_pos",   24'h000001, 24'h200000, 24'h000001, 1'b0);
    dir_vec("round_neg",   24'hFFFFFF, 24'h200000, 24'h000000, 1'b0);
`else
    dir_vec("round_pos",   24'h000001, 24'h200000, 24'h000000, 1'b0);
    dir_vec("round_neg",   24'hFFFFFF, 24'h200000, 24'hFFFFFF, 1'b0);
`endif

    // Backpressure: 20 random operands, out_ready random with a 10-cycle low window
    exp_q.delete();
    n_acc = 0;
    k = 0;
    while ((n_acc < 20 || exp_q.size() > 0) && k < 400) begin
      ra = 24'($urandom);
      rb = 24'($urandom);
      cycle((n_acc < 20) && ($urandom_range(3) != 0), ra, rb,
            (k >= 15 && k < 25) ? 1'b0 : 1'($urandom_range(1)), 1'b1, took, got);
      if (took) n_acc++;
      k++;
    end
    check("bp_accepted", 64'(n_acc), 64'd20);
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // Throughput: 50 back-to-back operands with out_ready held high
    exp_q.delete();
    first_c = -1; last_c = -1; cnt = 0;
    for (int i = 0; i < 50; i++) begin
      cycle(1'b1, 24'($urandom), 24'($urandom), 1'b1, 1'b1, took, got);
      if (got) begin
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        cnt++;
      end
    end
    k = 0;
    while (cnt < 50 && k < 30) begin
      cycle(1'b0, 24'd0, 24'd0, 1'b1, 1'b1, took, got);
      if (got) begin
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        cnt++;
      end
      k++;
    end
    check("tput_count", 64'(cnt), 64'd50);
    check("tput_continuous", 64'(last_c - first_c), 64'd49);

    // Reset with five operations in flight
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 24'($urandom), 24'($urandom), 1'b1, 1'b0, took, got);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_p", 64'(p), 64'd0);
    check("midrst_sat", 64'(sat), 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 24'd0, 24'd0, 1'b1, 1'b0, took, got);
      if (got) cnt++;
    end
    check("midrst_no_stale", 64'(cnt), 64'd0);
    dir_vec("post_rst",    24'h200000, 24'hC00000, 24'hE00000, 1'b0);

    // WIDTH=16 sweep: latency per PP_PER_STAGE, then random bit-exact stream
    check("w16_in_ready", 64'({ir16[0], ir16[1], ir16[2]}), 64'h7);
    for (int i = 0; i < 3; i++) lat16[i] = 0;
    cyc16(1'b1, 16'h4000, 16'h2000, g3);
    for (int t = 1; t <= 15; t++) begin
      cyc16(1'b0, 16'h0, 16'h0, g3);
      for (int i = 0; i < 3; i++) if (g3[i] && lat16[i] == 0) lat16[i] = t;
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("w16_pps%0d_latency", pps16[i]), 64'(lat16[i]), 64'(lat16_exp[i]));
    end
    for (int i = 0; i < 12; i++) cyc16(1'b1, 16'($urandom), 16'($urandom), g3);
    cyc16(1'b1, 16'h8000, 16'h8000, g3);
    cyc16(1'b1, 16'h8000, 16'h4000, g3);
    for (int i = 0; i < 15; i++) cyc16(1'b0, 16'h0, 16'h0, g3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("w16_pps%0d_count", pps16[i]), 64'(idx16[i]), 64'(n16));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
